// File: rtl/adder_pkg.sv
// adder_pkg: settings shared by the byte-serial adder datapath (operand
// serializer, adder, result deserializer).
//   DATA_W     - full operand width
//   SLICE_W    - slice width carried per transfer
//   NUM_SLICES - transfers per operand pair
//   IDX_W      - width of a slice index
//   ST_*       - serializer FSM state encodings
package adder_pkg;

    localparam int DATA_W     = 32;
    localparam int SLICE_W    = 8;
    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/operand_serializer.sv
// operand_serializer: takes one full-width operand pair plus carry-in and
// presents it LSB slice first, one SLICE_W slice per transfer, to the
// byte-serial adder. A new pair can be taken on the same cycle the last
// slice of the previous pair transfers, so pairs stream without a bubble.
//
// Ports:
//   TClk       clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   / in_ready  : input handshake for in_a, in_b, in_cin
//   in_a, in_b             : operands
//   in_cin                 : carry-in of the whole addition
//   out_valid  / out_ready : output handshake for one slice
//   out_ra, out_rb         : current slice, zero-extended to DATA_W
//   out_cin                : captured carry-in, stable for the whole pair
//   out_first, out_last    : slice is slice 0 / slice NUM_SLICES-1
//   out_idx                : index of the current slice
//   fsm_state              : current FSM state (ST_IDLE / ST_SEND), debug only
//
// Handshake: on both sides a transfer happens on a rising edge where valid
// and ready are both 1. The producer holds valid and its data stable until
// that transfer; valid never depends on ready. in_ready does depend
// combinationally on out_ready during the last slice so the next pair can be
// taken without an idle cycle.
module operand_serializer
    import adder_pkg::*;
#(
    parameter int DATA_W  = adder_pkg::DATA_W,
    parameter int SLICE_W = adder_pkg::SLICE_W
) (
    input  logic                                  TClk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_W-1:0]                     in_a,
    input  logic [DATA_W-1:0]                     in_b,
    input  logic                                  in_cin,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_W-1:0]                     out_ra,
    output logic [DATA_W-1:0]                     out_rb,
    output logic                                  out_cin,
    output logic                                  out_first,
    output logic                                  out_last,
    output logic [$clog2(DATA_W/SLICE_W)-1:0]     out_idx,
    output logic [0:0]                            fsm_state
);

    localparam int N_SL = DATA_W / SLICE_W;
    localparam int IW   = $clog2(DATA_W / SLICE_W);

    localparam logic [IW-1:0] IDX_LAST = IW'(N_SL - 1);
    // Index whose transfer moves us onto the last slice.
    localparam logic [IW-1:0] IDX_PRE_LAST = IW'(N_SL - 2);

    logic [0:0]        state_q;
    logic [DATA_W-1:0] sa_q;
    logic [DATA_W-1:0] sb_q;
    logic              scin_q;
    logic [IW-1:0]     idx_q;
    logic              first_q;
    logic              last_q;

    logic xfer;
    logic load;

    assign out_valid = (state_q == ST_SEND);
    assign xfer      = out_valid && out_ready;
    assign in_ready  = (state_q == ST_IDLE) || (xfer && last_q);
    assign load      = in_valid && in_ready;

    always_ff @(posedge TClk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            scin_q  <= 1'b0;
            idx_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load) begin
            // Covers both the IDLE accept and the back-to-back accept on the
            // last slice of the previous pair.
            state_q <= ST_SEND;
            sa_q    <= in_a;
            sb_q    <= in_b;
            scin_q  <= in_cin;
            idx_q   <= '0;
            first_q <= 1'b1;
            last_q  <= (N_SL == 1);
        end else if (xfer) begin
            if (last_q) begin
                // Pair finished with nothing waiting: drop to IDLE. Slice
                // data is left as is; it is only meaningful with out_valid.
                state_q <= ST_IDLE;
                first_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                sa_q    <= sa_q >> SLICE_W;
                sb_q    <= sb_q >> SLICE_W;
                idx_q   <= idx_q + 1'b1;
                first_q <= 1'b0;
                last_q  <= (idx_q == IDX_PRE_LAST);
            end
        end
    end

    // Upper bits are forced to zero so the adder only ever sees one slice.
    always_comb begin
        out_ra                = '0;
        out_rb                = '0;
        out_ra[SLICE_W-1:0]   = sa_q[SLICE_W-1:0];
        out_rb[SLICE_W-1:0]   = sb_q[SLICE_W-1:0];
    end

    assign out_cin   = scin_q;
    assign out_first = first_q;
    assign out_last  = last_q;
    assign out_idx   = idx_q;
    assign fsm_state = state_q;

    // IDX_LAST is kept for readability of the index range; tie it into a
    // harmless use so the intent is documented in one place.
    logic idx_at_last;
    assign idx_at_last = (idx_q == IDX_LAST);
    logic unused_ok;
    assign unused_ok = idx_at_last & 1'b0;

endmodule

// File: doc/operand_serializer.md
Name: operand_serializer

Overview:
Upstream feeder for the byte-serial 32-bit Adder. Accepts one full-width operand pair plus carry-in through a valid/ready handshake, then presents it LSB-slice first, one SLICE_W slice per transfer, on the Adder's ra/rb/cin inputs. Downstream stalls are honoured. Consecutive operand pairs stream with no bubble between them.

Parameters:
DATA_W, 32, operand width; must be an integer multiple of SLICE_W
SLICE_W, 8, slice width presented per transfer
NUM_SLICES, DATA_W/SLICE_W (derived localparam, 4), transfers per operand pair

Ports:
TClk  in  1  single clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair on in_a/in_b/in_cin is valid
in_ready  out  1  block accepts the pair this cycle
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
in_cin  in  1  carry-in for the whole addition
out_valid  out  1  slice on out_ra/out_rb is valid
out_ready  in  1  downstream Adder consumes the slice this cycle
out_ra  out  DATA_W  current slice of A in bits [SLICE_W-1:0]; upper bits always 0
out_rb  out  DATA_W  current slice of B in bits [SLICE_W-1:0]; upper bits always 0
out_cin  out  1  captured carry-in, held stable for all slices of a pair
out_first  out  1  current slice is slice 0
out_last  out  1  current slice is slice NUM_SLICES-1
out_idx  out  clog2(NUM_SLICES)  index of current slice, 0..NUM_SLICES-1

Behaviour:
- Reset (async assert, sync release): state IDLE. out_valid, out_ra, out_rb, out_cin, out_first, out_last and out_idx are all 0. in_ready is 1 once rst deasserts.
- FSM has two states, IDLE and SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1: capture in_a, in_b and in_cin into shift registers sa/sb/scin, set idx=0, go to SEND.
  - out_valid=1 on the next cycle, so latency from input handshake to slice 0 is 1 cycle.
- SEND:
  - out_valid=1.
  - out_ra = zero-extended sa[SLICE_W-1:0]; out_rb likewise from sb. All outputs come straight from registers.
  - out_first = (idx==0); out_last = (idx==NUM_SLICES-1); out_cin = scin.
  - A transfer occurs when out_valid && out_ready.
  - On a transfer with idx<NUM_SLICES-1: shift sa and sb right by SLICE_W (zero-fill) and increment idx.
  - On out_ready=0: all outputs hold unchanged, with no limit on stall length.
- Last-slice transfer:
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is a combinational path from out_ready, which is intentional.
  - If in_valid is also 1 in that cycle: load the new pair, idx=0, stay in SEND. Slice 0 of the new pair appears in the next cycle with no bubble.
  - Otherwise go to IDLE; out_valid falls next cycle.
- in_valid asserted during SEND on a non-last slice is not accepted (in_ready=0). Input data is ignored and the upstream must hold it.
- Sum of a pair is defined as (in_a + in_b + in_cin) mod 2^DATA_W, with carry-out produced by the Adder. This block performs no arithmetic.
- Reset mid-SEND: the in-flight pair is discarded and outputs go to reset values immediately (asynchronously). No partial slice is re-emitted after release.
- Upper bits of out_ra/out_rb are never non-zero, so the Adder sees exactly the values a%2^SLICE_W.

Decomposition:
- Shared package adder_pkg holds:
  - DATA_W and SLICE_W defaults.
  - NUM_SLICES.
  - IDX_W = clog2(NUM_SLICES).
  - State encoding constants ST_IDLE=0 and ST_SEND=1.
- Package is shared with the Adder and the result deserializer.
- No sub-module: FSM, shift registers and counter stay in one module.

Test Plan:
1. Reset with rst=1 mid-run -> out_valid=0, out_ra=out_rb=0, out_idx=0 during reset; in_ready=1 the first cycle after release.
2. Pair a=0x12345678, b=0x9ABCDEF0, cin=1, out_ready=1 -> (ra,rb) = (78,F0),(56,DE),(34,BC),(12,9A) on 4 consecutive cycles starting 1 cycle after accept.
   - out_cin=1 throughout; out_first only on slice 0; out_last only on slice 3.
3. Same pair with out_ready=0 for 3 cycles at idx=1 -> (56,DE) held for 4 cycles, then (34,BC); in_ready stays 0 throughout.
4. Back-to-back: second pair a=0xFFFFFFFF, b=0x00000001, cin=0 presented with in_valid=1 during slice 3 of pair 1 -> accepted that cycle.
   - Next cycle shows (FF,01) with idx=0; no idle cycle between pairs.
5. in_valid=1 with a=0xDEADBEEF during idx=1 of a transfer -> not accepted (in_ready=0); in-flight slices unchanged.
6. Reset asserted at idx=2 -> outputs clear asynchronously; after release, a new pair a=0x000000AA, b=0x00000055 yields first slice (AA,55) with idx=0.
